// File: rtl/fp_tomasulo_pkg.sv
// Shared widths, tag/register constants and the CDB packet type for the
// Tomasulo FP writeback path.
package fp_tomasulo_pkg;

    localparam int DATA_W   = 16;
    localparam int TAG_W    = 3;
    localparam int NUM_REGS = 6;
    localparam int ADDR_W   = 3;

    localparam logic [TAG_W-1:0]  TAG_NONE = '0;

    localparam logic [ADDR_W-1:0] REG_R1 = 3'd1;
    localparam logic [ADDR_W-1:0] REG_R2 = 3'd2;
    localparam logic [ADDR_W-1:0] REG_R3 = 3'd3;
    localparam logic [ADDR_W-1:0] REG_R4 = 3'd4;
    localparam logic [ADDR_W-1:0] REG_R5 = 3'd5;
    localparam logic [ADDR_W-1:0] REG_R6 = 3'd6;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } cdb_pkt_t;

endpackage

// File: rtl/wb_fifo.sv
// Small result buffer in front of the CDB arbiter. Ready depends only on the
// current occupancy, so a full buffer refuses a push even while it is popping.
module wb_fifo
    import fp_tomasulo_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  cdb_pkt_t         i_pkt,
    input  logic             i_pop,
    output cdb_pkt_t         o_head,
    output logic             o_ready,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cdb_pkt_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_ready = (r_count < CNT_W'(DEPTH));
    assign w_push  = i_push && o_ready;
    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_pkt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_writeback.sv
// CDB writeback: buffers adder/multiplier results, round-robin broadcasts them,
// owns the Qi table and drives the FP register file write port.
// Optional statistics counters are built when CDB_STATS_EN is defined.
module cdb_writeback
    import fp_tomasulo_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      add_valid,
    output logic                      add_ready,
    input  logic [TAG_W-1:0]          add_tag,
    input  logic [DATA_W-1:0]         add_value,
    input  logic                      mul_valid,
    output logic                      mul_ready,
    input  logic [TAG_W-1:0]          mul_tag,
    input  logic [DATA_W-1:0]         mul_value,
    input  logic                      issue_en,
    input  logic [ADDR_W-1:0]         issue_reg,
    input  logic [TAG_W-1:0]          issue_tag,
    output logic [NUM_REGS*TAG_W-1:0] qi_flat,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_value,
    output logic [DATA_W-1:0]         rf_dataIn,
    output logic [ADDR_W-1:0]         rf_dataAddress,
`ifdef CDB_STATS_EN
    output logic [15:0]               stat_bcast,
    output logic [15:0]               stat_stall,
`endif
    output logic                      rf_writeEnable
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    cdb_pkt_t          w_add_in;
    cdb_pkt_t          w_mul_in;
    cdb_pkt_t          w_add_head;
    cdb_pkt_t          w_mul_head;
    cdb_pkt_t          w_pkt;
    logic [CNT_W-1:0]  w_add_count;
    logic [CNT_W-1:0]  w_mul_count;
    logic              w_add_nonempty;
    logic              w_mul_nonempty;
    logic              w_grant_add;
    logic              w_grant_mul;
    logic              w_grant;
    logic              w_match;
    logic [ADDR_W-1:0] w_match_reg;
    logic              w_issue_ok;
    logic              r_last_mul;
    logic [TAG_W-1:0]  r_qi [1:NUM_REGS];

    assign w_add_in = '{tag: add_tag, value: add_value};
    assign w_mul_in = '{tag: mul_tag, value: mul_value};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_add_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (add_valid),
        .i_pkt   (w_add_in),
        .i_pop   (w_grant_add),
        .o_head  (w_add_head),
        .o_ready (add_ready),
        .o_count (w_add_count)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mul_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (mul_valid),
        .i_pkt   (w_mul_in),
        .i_pop   (w_grant_mul),
        .o_head  (w_mul_head),
        .o_ready (mul_ready),
        .o_count (w_mul_count)
    );

    assign w_add_nonempty = (w_add_count != '0);
    assign w_mul_nonempty = (w_mul_count != '0);

    // r_last_mul set means the multiplier won last, so the adder is preferred next.
    always_comb begin
        w_grant_add = w_add_nonempty && (!w_mul_nonempty || r_last_mul);
        w_grant_mul = w_mul_nonempty && (!w_add_nonempty || !r_last_mul);
        w_grant     = w_grant_add || w_grant_mul;
        w_pkt       = w_grant_mul ? w_mul_head : w_add_head;
    end

    always_comb begin
        w_match     = 1'b0;
        w_match_reg = '0;
        for (int r = 1; r <= NUM_REGS; r++) begin
            if (w_grant && (w_pkt.tag != TAG_NONE) && (r_qi[r] == w_pkt.tag)) begin
                w_match     = 1'b1;
                w_match_reg = ADDR_W'(r);
            end
        end
    end

    assign w_issue_ok = issue_en && (issue_reg >= REG_R1) && (issue_reg <= REG_R6);

    always_comb begin
        qi_flat = '0;
        for (int r = 1; r <= NUM_REGS; r++) begin
            qi_flat[(r-1)*TAG_W +: TAG_W] = r_qi[r];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_mul     <= 1'b1;
            cdb_valid      <= 1'b0;
            cdb_tag        <= '0;
            cdb_value      <= '0;
            rf_writeEnable <= 1'b0;
            rf_dataAddress <= '0;
            rf_dataIn      <= '0;
            for (int r = 1; r <= NUM_REGS; r++) begin
                r_qi[r] <= TAG_NONE;
            end
        end else begin
            cdb_valid <= w_grant;
            if (w_grant) begin
                r_last_mul <= w_grant_mul;
                cdb_tag    <= w_pkt.tag;
                cdb_value  <= w_pkt.value;
            end
            rf_writeEnable <= w_match;
            if (w_match) begin
                rf_dataAddress <= w_match_reg;
                rf_dataIn      <= w_pkt.value;
            end
            // Issue is applied after the clear so a same-edge rename wins.
            for (int r = 1; r <= NUM_REGS; r++) begin
                if (w_match && (w_match_reg == ADDR_W'(r))) begin
                    r_qi[r] <= TAG_NONE;
                end
                if (w_issue_ok && (issue_reg == ADDR_W'(r))) begin
                    r_qi[r] <= issue_tag;
                end
            end
        end
    end

`ifdef CDB_STATS_EN
    logic w_stall;
    assign w_stall = (add_valid && !add_ready) || (mul_valid && !mul_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_bcast <= '0;
            stat_stall <= '0;
        end else begin
            if (w_grant && (stat_bcast != 16'hFFFF)) begin
                stat_bcast <= stat_bcast + 16'd1;
            end
            if (w_stall && (stat_stall != 16'hFFFF)) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_writeback.sv
// Directed and randomized checks of cdb_writeback against a queue-based model
// of the writeback stage (per-unit result queues plus a Qi array).
module tb_cdb_writeback;

    localparam int FIFO_DEPTH = 2;

    logic        clock;
    logic        reset;
    logic        add_valid;
    logic        add_ready;
    logic [2:0]  add_tag;
    logic [15:0] add_value;
    logic        mul_valid;
    logic        mul_ready;
    logic [2:0]  mul_tag;
    logic [15:0] mul_value;
    logic        issue_en;
    logic [2:0]  issue_reg;
    logic [2:0]  issue_tag;
    logic [17:0] qi_flat;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_value;
    logic [15:0] rf_dataIn;
    logic [2:0]  rf_dataAddress;
    logic        rf_writeEnable;
`ifdef CDB_STATS_EN
    logic [15:0] stat_bcast;
    logic [15:0] stat_stall;
`endif

    cdb_writeback #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .add_valid      (add_valid),
        .add_ready      (add_ready),
        .add_tag        (add_tag),
        .add_value      (add_value),
        .mul_valid      (mul_valid),
        .mul_ready      (mul_ready),
        .mul_tag        (mul_tag),
        .mul_value      (mul_value),
        .issue_en       (issue_en),
        .issue_reg      (issue_reg),
        .issue_tag      (issue_tag),
        .qi_flat        (qi_flat),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_value      (cdb_value),
        .rf_dataIn      (rf_dataIn),
        .rf_dataAddress (rf_dataAddress),
`ifdef CDB_STATS_EN
        .stat_bcast     (stat_bcast),
        .stat_stall     (stat_stall),
`endif
        .rf_writeEnable (rf_writeEnable)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference model: pending results per unit, Qi per register, expected outputs
    logic [18:0] add_q[$];
    logic [18:0] mul_q[$];
    logic [2:0]  m_qi [1:6];
    bit          m_prefer_add;
    logic        m_cdb_valid;
    logic [2:0]  m_cdb_tag;
    logic [15:0] m_cdb_value;
    logic        m_we;
    logic [2:0]  m_addr;
    logic [15:0] m_data;
    int          m_bcast;
    int          m_stall;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    task automatic model_reset();
        add_q.delete();
        mul_q.delete();
        for (int r = 1; r <= 6; r++) m_qi[r] = 3'd0;
        m_prefer_add = 1'b1;
        m_cdb_valid  = 1'b0;
        m_cdb_tag    = '0;
        m_cdb_value  = '0;
        m_we         = 1'b0;
        m_addr       = '0;
        m_data       = '0;
        m_bcast      = 0;
        m_stall      = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [18:0] pkt;
        bit add_acc, mul_acc, from_add, from_mul;
        int hit;
        if (reset) begin
            model_reset();
            return;
        end
        add_acc = add_valid && (add_q.size() < FIFO_DEPTH);
        mul_acc = mul_valid && (mul_q.size() < FIFO_DEPTH);
        if ((add_valid && !add_acc) || (mul_valid && !mul_acc))
            m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
        from_add = (add_q.size() > 0) && ((mul_q.size() == 0) || m_prefer_add);
        from_mul = (mul_q.size() > 0) && !from_add;
        m_cdb_valid = 1'b0;
        m_we        = 1'b0;
        if (from_add || from_mul) begin
            pkt = from_add ? add_q.pop_front() : mul_q.pop_front();
            m_prefer_add = from_mul;
            m_cdb_valid  = 1'b1;
            m_cdb_tag    = pkt[18:16];
            m_cdb_value  = pkt[15:0];
            m_bcast      = (m_bcast < 65535) ? m_bcast + 1 : m_bcast;
            hit = 0;
            if (m_cdb_tag != 3'd0)
                for (int r = 1; r <= 6; r++) if (m_qi[r] == m_cdb_tag) hit = r;
            if (hit != 0) begin
                m_we   = 1'b1;
                m_addr = 3'(hit);
                m_data = m_cdb_value;
                m_qi[hit] = 3'd0;
            end
        end
        if (add_acc) add_q.push_back({add_tag, add_value});
        if (mul_acc) mul_q.push_back({mul_tag, mul_value});
        if (issue_en && (issue_reg >= 3'd1) && (issue_reg <= 3'd6))
            m_qi[issue_reg] = issue_tag;
    endtask

    task automatic check_all();
        logic [17:0] exp_qi;
        for (int r = 1; r <= 6; r++) exp_qi[(r-1)*3 +: 3] = m_qi[r];
        chk("cdb_valid", 32'(cdb_valid), 32'(m_cdb_valid));
        chk("cdb_tag", 32'(cdb_tag), 32'(m_cdb_tag));
        chk("cdb_value", 32'(cdb_value), 32'(m_cdb_value));
        chk("rf_we", 32'(rf_writeEnable), 32'(m_we));
        if (m_we) begin
            chk("rf_addr", 32'(rf_dataAddress), 32'(m_addr));
            chk("rf_data", 32'(rf_dataIn), 32'(m_data));
        end
        chk("add_ready", 32'(add_ready), 32'(add_q.size() < FIFO_DEPTH));
        chk("mul_ready", 32'(mul_ready), 32'(mul_q.size() < FIFO_DEPTH));
        chk("qi_flat", 32'(qi_flat), 32'(exp_qi));
`ifdef CDB_STATS_EN
        chk("stat_bcast", 32'(stat_bcast), 32'(m_bcast));
        chk("stat_stall", 32'(stat_stall), 32'(m_stall));
`endif
    endtask

    // driver tasks
    task automatic idle_inputs();
        add_valid = 1'b0; add_tag = '0; add_value = '0;
        mul_valid = 1'b0; mul_tag = '0; mul_value = '0;
        issue_en  = 1'b0; issue_reg = '0; issue_tag = '0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check_all();
        idle_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic push_add(input logic [2:0] t, input logic [15:0] v);
        add_valid = 1'b1; add_tag = t; add_value = v;
    endtask

    task automatic push_mul(input logic [2:0] t, input logic [15:0] v);
        mul_valid = 1'b1; mul_tag = t; mul_value = v;
    endtask

    task automatic issue(input logic [2:0] r, input logic [2:0] t);
        issue_en = 1'b1; issue_reg = r; issue_tag = t;
    endtask

    initial begin
        bit saw_mul_low;
        bit dup;
        reset = 1'b1;
        idle_inputs();
        model_reset();

        // reset state
        do_reset();
        chk("reset_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("reset_ready", 32'({add_ready, mul_ready}), 32'd3);
        chk("reset_qi", 32'(qi_flat), 32'd0);

        // simple rename then writeback to R4
        issue(3'd4, 3'd2);
        cycle();
        push_add(3'd2, 16'h0040);
        cycle();
        cycle();
        chk("t1_cdb", 32'({cdb_valid, cdb_tag, cdb_value}), 32'({1'b1, 3'd2, 16'h0040}));
        chk("t1_rf", 32'({rf_writeEnable, rf_dataAddress, rf_dataIn}), 32'({1'b1, 3'd4, 16'h0040}));
        chk("t1_qi_r4", 32'(qi_flat[11:9]), 32'd0);

        // simultaneous pushes from both units
        do_reset();
        push_add(3'd1, 16'h1111);
        push_mul(3'd5, 16'h5555);
        cycle();
        cycle();
        chk("t2_first_tag", 32'(cdb_tag), 32'd1);
        cycle();
        chk("t2_second_tag", 32'(cdb_tag), 32'd5);
        push_add(3'd2, 16'h2222);
        push_mul(3'd6, 16'h6666);
        cycle();
        cycle();
        cycle();
        cycle();

        // WAW: the older tag broadcasts without a register write
        issue(3'd2, 3'd3);
        cycle();
        issue(3'd2, 3'd6);
        cycle();
        push_mul(3'd3, 16'h0333);
        cycle();
        cycle();
        chk("t3_cdb_valid", 32'(cdb_valid), 32'd1);
        chk("t3_rf_we", 32'(rf_writeEnable), 32'd0);
        chk("t3_qi_r2", 32'(qi_flat[5:3]), 32'd6);

        // back-pressure on the multiplier while both units stream
        saw_mul_low = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_add(3'(1 + i), 16'($urandom));
            push_mul(3'(4 + (i % 3)), 16'h0A00 + 16'(i));
            cycle();
            if (!mul_ready || !add_ready) saw_mul_low = 1'b1;
        end
        for (int i = 0; i < 6; i++) cycle();
        chk("t4_backpressure_seen", 32'(saw_mul_low), 32'd1);

        // same-edge clear and re-issue on R1
        issue(3'd1, 3'd7);
        cycle();
        push_add(3'd7, 16'h7777);
        cycle();
        issue(3'd1, 3'd4);
        cycle();
        chk("t5_rf", 32'({rf_writeEnable, rf_dataAddress}), 32'({1'b1, 3'd1}));
        chk("t5_qi_r1", 32'(qi_flat[2:0]), 32'd4);

        // reset with buffered results
        for (int i = 0; i < 4; i++) begin
            push_add(3'd1, 16'($urandom));
            push_mul(3'd2, 16'($urandom));
            cycle();
        end
        do_reset();
        for (int i = 0; i < 3; i++) cycle();
        chk("t6_no_bcast", 32'(cdb_valid), 32'd0);
        chk("t6_ready", 32'({add_ready, mul_ready}), 32'd3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1) push_add(3'($urandom_range(0, 7)), 16'($urandom));
            if ($urandom_range(0, 1) == 1) push_mul(3'($urandom_range(0, 7)), 16'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                dup = 1'b0;
                for (int r = 1; r <= 6; r++)
                    if ((3'(r) != issue_reg) && (issue_tag != 3'd0) && (m_qi[r] == issue_tag)) dup = 1'b1;
                if (dup) issue_en = 1'b0;
            end
            reset = ($urandom_range(0, 63) == 0);
            cycle();
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
